seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised WIDTH-bit ALU with registered results, a valid/ready handshake on both sides, and an iterative shift-add unsigned multiply.
- Supersedes the combinational ripple ALU in the datapath for any path that needs multi-cycle operations.
- Produces zero, carry-out and overflow flags alongside every result.

Parameters:
- WIDTH, 32, operand/result width in bits (legal range 4..64).
- MUL_EN, 1, 1 = MUL opcode legal; 0 = MUL is treated as an illegal opcode.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands and opcode are presented.
- in_ready  out  1  block can accept an operation.
- src1  in  WIDTH  operand A.
- src2  in  WIDTH  operand B.
- alu_ctrl  in  4  opcode.
- out_valid  out  1  result and flags are valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  registered result.
- zero  out  1  result == 0.
- cout  out  1  adder carry-out.
- overflow  out  1  signed overflow (ADD/SUB) or multiply overflow.
- illegal  out  1  the opcode was not recognised.

Behaviour:
- Opcodes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR, 1000 MUL. All other opcodes are illegal.
- Reset (asynchronous, rst_n=0):
  - state=IDLE; in_ready=1 once reset is released.
  - out_valid, result, zero, cout, overflow and illegal are all 0.
  - Any in-flight multiply is discarded.
- FSM states: IDLE, MUL, DONE.
  - in_ready=1 only in IDLE.
  - Acceptance occurs when in_valid && in_ready at a rising edge; operands and opcode are captured.
- IDLE to DONE: on accept of a non-MUL opcode, or of an illegal opcode. The result registers load at that edge, so out_valid=1 one cycle after accept.
- IDLE to MUL: on accept of MUL (MUL_EN=1).
  - Load multiplicand=src1, multiplier=src2, accumulator=0 (2*WIDTH bits), counter=0.
- MUL iteration, one step per cycle:
  - If multiplier[0]=1, add multiplicand (shifted left by counter) into the accumulator.
  - Shift the multiplier right; increment the counter.
  - After exactly WIDTH steps, go to DONE with result=acc[WIDTH-1:0] and overflow=|acc[2W-1:W].
  - out_valid rises WIDTH+1 cycles after accept.
  - No early termination; latency is fixed.
- DONE: out_valid=1. All outputs are held stable while out_ready=0. When out_ready=1, go to IDLE at that edge and drop out_valid.
  - No back-to-back issue: the next accept happens no earlier than the cycle after the handoff.
- Arithmetic (width WIDTH):
  - SUB/SLT compute src1 + ~src2 + 1. cout is the carry-out of the MSB; for SUB, cout=1 means no borrow.
  - overflow (ADD/SUB) = carry into MSB XOR carry out of MSB.
  - SLT: result = {(WIDTH-1){0}, sign XOR overflow}, which is correct for the signed compare. SLT reports cout from the subtraction and overflow=0.
  - AND/OR/NOR: cout=0, overflow=0.
  - MUL: cout=0; the product is unsigned.
- zero is computed from the final registered result.
- Illegal opcode: result=0, zero=1, cout=0, overflow=0, illegal=1, still one-cycle latency. illegal=0 for every legal op.
- in_valid while busy (MUL or DONE): ignored. The source must hold its inputs until in_ready.
- Inputs changing during MUL: no effect, because the operands were captured at accept.
- Reset asserted in MUL or DONE: immediate return to IDLE; no result is produced.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams (OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR, OP_MUL);
  - the FSM state encoding (ST_IDLE=2'd0, ST_MUL=2'd1, ST_DONE=2'd2).
- One sub-module: alu_addsub, a combinational WIDTH-bit adder with sub input.
  - Outputs sum, cout and overflow.
  - Instantiated once for ADD/SUB/SLT. The MUL accumulator uses its own 2*WIDTH adder.

Test Plan (WIDTH=8):
- Reset mid-MUL: accept MUL 0x0F*0x03, assert rst_n=0 in cycle 3 -> out_valid=0 and result=0 immediately; in_ready=1 after release; no result emerges.
- ADD overflow: 0x7F + 0x01 -> out_valid 1 cycle after accept; result=0x80, overflow=1, cout=0, zero=0.
- SUB and SLT:
  - SUB 0x05 - 0x05 -> result=0x00, zero=1, cout=1, overflow=0.
  - SLT 0x80 vs 0x01 -> result=0x01.
  - SLT 0x01 vs 0x80 -> result=0x00.
- MUL latency/overflow:
  - 0x10 * 0x10 -> out_valid exactly 9 cycles after accept; result=0x00, overflow=1, zero=1.
  - 0x0F * 0x03 -> result=0x2D, overflow=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> outputs stable, in_ready=0, a new in_valid is ignored; on out_ready=1, in_ready returns the next cycle.
- Illegal opcode: alu_ctrl=1111 -> result=0, zero=1, illegal=1 after 1 cycle; with MUL_EN=0, opcode 1000 -> illegal=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcodes and FSM encoding for the sequential ALU.
// Imported by seq_alu and its testbench.
package alu_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;
    localparam logic [3:0] OP_MUL = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_addsub.sv
// Combinational WIDTH-bit adder/subtractor with carry-out
// and signed overflow.
module alu_addsub #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    logic [WIDTH-1:0] bx;
    logic             c_msb_in;

    assign bx = b ^ {WIDTH{sub}};

    assign {cout, sum} = {1'b0, a} + {1'b0, bx}
                       + {{WIDTH{1'b0}}, sub};

    // carry into the MSB recovered from the MSB sum bit
    assign c_msb_in = a[WIDTH-1] ^ bx[WIDTH-1] ^ sum[WIDTH-1];
    assign overflow = c_msb_in ^ cout;

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with valid/ready handshakes and an
// iterative shift-add unsigned multiplier.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic [3:0]       alu_ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             cout,
    output logic             overflow,
    output logic             illegal
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t state, state_n;

    logic               accept;
    logic               is_mul;
    logic               last_step;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;

    logic               as_sub;
    logic [WIDTH-1:0]   as_sum;
    logic               as_cout;
    logic               as_ovf;

    logic [WIDTH-1:0]   alu_res;
    logic               alu_c;
    logic               alu_o;
    logic               alu_ill;

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign accept    = in_valid && in_ready;
    assign is_mul    = MUL_EN && (alu_ctrl == OP_MUL);
    assign last_step = (cnt == CW'(WIDTH - 1));
    assign as_sub    = (alu_ctrl == OP_SUB) || (alu_ctrl == OP_SLT);
    assign acc_nxt   = mplier[0] ? acc + mcand : acc;

    alu_addsub #(
        .WIDTH(WIDTH)
    ) u_addsub (
        .a        (src1),
        .b        (src2),
        .sub      (as_sub),
        .sum      (as_sum),
        .cout     (as_cout),
        .overflow (as_ovf)
    );

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_o   = 1'b0;
        alu_ill = 1'b0;
        unique case (1'b1)
            (alu_ctrl == OP_AND): alu_res = src1 & src2;
            (alu_ctrl == OP_OR):  alu_res = src1 | src2;
            (alu_ctrl == OP_NOR): alu_res = ~(src1 | src2);
            (alu_ctrl == OP_ADD),
            (alu_ctrl == OP_SUB): begin
                alu_res = as_sum;
                alu_c   = as_cout;
                alu_o   = as_ovf;
            end
            (alu_ctrl == OP_SLT): begin
                alu_res = {{(WIDTH-1){1'b0}}, as_sum[WIDTH-1] ^ as_ovf};
                alu_c   = as_cout;
            end
            default: alu_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: begin
                if (accept) state_n = is_mul ? ST_MUL : ST_DONE;
            end
            ST_MUL: begin
                if (last_step) state_n = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result   <= '0;
            zero     <= 1'b0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            illegal  <= 1'b0;
            mcand    <= '0;
            acc      <= '0;
            mplier   <= '0;
            cnt      <= '0;
        end else if (accept && is_mul) begin
            mcand  <= {{WIDTH{1'b0}}, src1};
            mplier <= src2;
            acc    <= '0;
            cnt    <= '0;
        end else if (accept) begin
            result   <= alu_res;
            zero     <= (alu_res == '0);
            cout     <= alu_c;
            overflow <= alu_o;
            illegal  <= alu_ill;
        end else if (state == ST_MUL) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (last_step) begin
                result   <= acc_nxt[WIDTH-1:0];
                zero     <= (acc_nxt[WIDTH-1:0] == '0);
                cout     <= 1'b0;
                overflow <= |acc_nxt[2*WIDTH-1:WIDTH];
                illegal  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH=8) with an arithmetic
// reference model and a per-cycle output scoreboard.
module tb_seq_alu;
    import alu_pkg::*;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] r;
        logic         z;
        logic         c;
        logic         o;
        logic         i;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid, in_ready;
    logic [W-1:0] src1, src2;
    logic [3:0]   alu_ctrl;
    logic         out_valid, out_ready;
    logic [W-1:0] result;
    logic         zero, cout, overflow, illegal;

    logic         in_valid2, in_ready2;
    logic         out_valid2, out_ready2;
    logic [W-1:0] result2;
    logic         zero2, cout2, overflow2, illegal2;

    int   n_chk = 0;
    int   n_fail = 0;
    int   valid_seen = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(W), .MUL_EN(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .src1      (src1),
        .src2      (src2),
        .alu_ctrl  (alu_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .cout      (cout),
        .overflow  (overflow),
        .illegal   (illegal)
    );

    seq_alu #(.WIDTH(W), .MUL_EN(1'b0)) dut_nomul (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .src1      (src1),
        .src2      (src2),
        .alu_ctrl  (alu_ctrl),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .result    (result2),
        .zero      (zero2),
        .cout      (cout2),
        .overflow  (overflow2),
        .illegal   (illegal2)
    );

    task automatic chk(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op,
                                   input logic [W-1:0] a,
                                   input logic [W-1:0] b,
                                   input bit mul_en);
        exp_t e;
        int   s, sa, sb, p;
        e  = '0;
        sa = int'($signed(a));
        sb = int'($signed(b));
        case (op)
            OP_AND: e.r = a & b;
            OP_OR:  e.r = a | b;
            OP_NOR: e.r = ~(a | b);
            OP_ADD: begin
                s   = int'(a) + int'(b);
                e.r = s[W-1:0];
                e.c = s[W];
                e.o = (sa + sb > 127) || (sa + sb < -128);
            end
            OP_SUB: begin
                s   = int'(a) + (255 - int'(b)) + 1;
                e.r = s[W-1:0];
                e.c = s[W];
                e.o = (sa - sb > 127) || (sa - sb < -128);
            end
            OP_SLT: begin
                s   = int'(a) + (255 - int'(b)) + 1;
                e.r = (sa < sb) ? 8'd1 : 8'd0;
                e.c = s[W];
            end
            OP_MUL: begin
                if (mul_en) begin
                    p   = int'(a) * int'(b);
                    e.r = p[W-1:0];
                    e.o = (p > 255);
                end else begin
                    e.i = 1'b1;
                end
            end
            default: e.i = 1'b1;
        endcase
        e.z = (e.r == '0);
        return e;
    endfunction

    // Scoreboard: expectations queued at acceptance, checked
    // on every cycle out_valid is high, popped on handoff.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
            end else begin
                if (out_valid) begin
                    valid_seen++;
                    chk("pending_op", 64'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q[0];
                        chk("result", result, e.r);
                        chk("zero", zero, e.z);
                        chk("cout", cout, e.c);
                        chk("overflow", overflow, e.o);
                        chk("illegal", illegal, e.i);
                        if (out_ready) void'(exp_q.pop_front());
                    end
                end
                if (in_valid && in_ready)
                    exp_q.push_back(model(alu_ctrl, src1, src2, 1'b1));
            end
        end
    end

    task automatic issue(input logic [3:0] op,
                         input logic [W-1:0] a,
                         input logic [W-1:0] b,
                         input int lat,
                         output exp_t got);
        int n;
        @(posedge clk); #1;
        src1 = a;
        src2 = b;
        alu_ctrl = op;
        in_valid = 1'b1;
        chk("in_ready_idle", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        src1 = ~a;
        src2 = ~b;
        n = 1;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", n, lat);
        got = {result, zero, cout, overflow, illegal};
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp_t g;
        int   vs;
        in_valid   = 1'b0;
        in_valid2  = 1'b0;
        out_ready  = 1'b1;
        out_ready2 = 1'b1;
        src1       = '0;
        src2       = '0;
        alu_ctrl   = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_zero", zero, 0);
        chk("rst_cout", cout, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_illegal", illegal, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);

        issue(OP_ADD, 8'h7F, 8'h01, 1, g);
        chk("add_ovf", g, {8'h80, 1'b0, 1'b0, 1'b1, 1'b0});
        issue(OP_SUB, 8'h05, 8'h05, 1, g);
        chk("sub_eq", g, {8'h00, 1'b1, 1'b1, 1'b0, 1'b0});
        issue(OP_SLT, 8'h80, 8'h01, 1, g);
        chk("slt_lt", g.r, 8'h01);
        issue(OP_SLT, 8'h01, 8'h80, 1, g);
        chk("slt_ge", g.r, 8'h00);
        issue(OP_AND, 8'hF0, 8'h3C, 1, g);
        issue(OP_OR,  8'h0A, 8'h50, 1, g);
        issue(OP_NOR, 8'h0F, 8'hF0, 1, g);
        issue(OP_ADD, 8'hFF, 8'h01, 1, g);
        issue(OP_SUB, 8'h00, 8'h01, 1, g);
        issue(OP_MUL, 8'h10, 8'h10, W + 1, g);
        chk("mul_ovf", g, {8'h00, 1'b1, 1'b0, 1'b1, 1'b0});
        issue(OP_MUL, 8'h0F, 8'h03, W + 1, g);
        chk("mul_small", g, {8'h2D, 1'b0, 1'b0, 1'b0, 1'b0});
        issue(OP_MUL, 8'hFF, 8'hFF, W + 1, g);
        issue(4'b1111, 8'h12, 8'h34, 1, g);
        chk("illegal_op", g, {8'h00, 1'b1, 1'b0, 1'b0, 1'b1});

        // backpressure with a competing request held on the input
        @(posedge clk); #1;
        out_ready = 1'b0;
        src1 = 8'h12;
        src2 = 8'h34;
        alu_ctrl = OP_ADD;
        in_valid = 1'b1;
        @(posedge clk); #1;
        src1 = 8'hFF;
        src2 = 8'h00;
        alu_ctrl = OP_OR;
        chk("bp_valid", out_valid, 1);
        chk("bp_result", result, 8'h46);
        repeat (5) begin
            @(posedge clk); #1;
            chk("bp_in_ready", in_ready, 0);
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_result", result, 8'h46);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_drop_valid", out_valid, 0);
        chk("bp_in_ready_back", in_ready, 1);

        // reset in the middle of a multiply
        @(posedge clk); #1;
        src1 = 8'h0F;
        src2 = 8'h03;
        alu_ctrl = OP_MUL;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        vs = valid_seen;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_result", result, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("mid_rst_in_ready", in_ready, 1);
        repeat (12) @(posedge clk);
        #1;
        chk("mid_rst_no_result", valid_seen - vs, 0);

        // MUL opcode on the instance built without a multiplier
        @(posedge clk); #1;
        src1 = 8'h05;
        src2 = 8'h06;
        alu_ctrl = OP_MUL;
        in_valid2 = 1'b1;
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        chk("nomul_valid", out_valid2, 1);
        chk("nomul_illegal", illegal2, 1);
        chk("nomul_result", result2, 0);
        chk("nomul_zero", zero2, 1);
        @(posedge clk); #1;

        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
